// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: generates clk_cpu from the board clock and executes
// STEP / RUN / HALT debug commands against a small breakpoint table.
module cpu_run_ctrl #(
  parameter int NBP = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_idx,
  input  logic [31:0] cmd_data,
  input  logic [31:0] pc_chk,
  output logic        clk_cpu,
  output logic        running,
  output logic        stop_pulse,
  output logic [1:0]  stop_cause,
  output logic [1:0]  bp_idx,
  output logic        cmd_err,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

  localparam logic [2:0] OP_STEP  = 3'd0;
  localparam logic [2:0] OP_RUN   = 3'd1;
  localparam logic [2:0] OP_HALT  = 3'd2;
  localparam logic [2:0] OP_SETBP = 3'd3;
  localparam logic [2:0] OP_CLRBP = 3'd4;

  localparam logic [1:0] CAUSE_STEP = 2'd1;
  localparam logic [1:0] CAUSE_BP   = 2'd2;
  localparam logic [1:0] CAUSE_HALT = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] remain_q, remain_d;
  logic        mode_run_q, mode_run_d;
  logic        halt_pend_q, halt_pend_d;
  logic        ready_q;
  logic        clk_cpu_q;
  logic        running_q;
  logic        stop_pulse_q, stop_pulse_d;
  logic [1:0]  stop_cause_q, stop_cause_d;
  logic [1:0]  bp_idx_q, bp_idx_d;
  logic        cmd_err_q, cmd_err_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [3:0]  bp_en_q, bp_en_d;
  logic [31:0] bp_addr_q [4];

  logic        accept;
  logic        busy;
  logic        idx_bad;
  logic        bp_we;
  logic        hit;
  logic [1:0]  hit_idx;
  logic        stop;
  logic [1:0]  cause;

  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    mode_run_d   = mode_run_q;
    halt_pend_d  = halt_pend_q;
    stop_pulse_d = 1'b0;
    stop_cause_d = stop_cause_q;
    bp_idx_d     = bp_idx_q;
    cmd_err_d    = 1'b0;
    bp_en_d      = bp_en_q;
    bp_we        = 1'b0;
    stop         = 1'b0;
    cause        = 2'd0;
    hit          = 1'b0;
    hit_idx      = 2'd0;

    accept  = cmd_valid & ready_q;
    busy    = (state_q != S_IDLE);
    idx_bad = (int'(cmd_idx) >= NBP);

    // Descending scan so the lowest matching index is the one left standing.
    for (int i = NBP - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bp_addr_q[i] == pc_chk)) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept && cmd_op == OP_STEP) begin
          remain_d   = (cmd_data == 32'd0) ? 32'd1 : cmd_data;
          mode_run_d = 1'b0;
          state_d    = S_HI;
        end else if (accept && cmd_op == OP_RUN) begin
          mode_run_d = 1'b1;
          state_d    = S_HI;
        end
      end
      S_HI: state_d = S_LO;
      S_LO: begin
        if (halt_pend_q) begin
          stop  = 1'b1;
          cause = CAUSE_HALT;
        end else if (!mode_run_q) begin
          if (remain_q == 32'd1) begin
            stop  = 1'b1;
            cause = CAUSE_STEP;
          end else begin
            remain_d = remain_q - 32'd1;
          end
        end else if (hit) begin
          stop     = 1'b1;
          cause    = CAUSE_BP;
          bp_idx_d = hit_idx;
        end
        if (stop) begin
          state_d      = S_IDLE;
          stop_pulse_d = 1'b1;
          stop_cause_d = cause;
        end else begin
          state_d = S_HI;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Commands are judged against the pre-transition state.
    if (accept) begin
      case (cmd_op)
        OP_STEP, OP_RUN: if (busy) cmd_err_d = 1'b1;
        OP_HALT:         if (busy) halt_pend_d = 1'b1;
        OP_SETBP: begin
          if (idx_bad) cmd_err_d = 1'b1;
          else begin
            bp_we            = 1'b1;
            bp_en_d[cmd_idx] = 1'b1;
          end
        end
        OP_CLRBP: begin
          if (idx_bad) cmd_err_d = 1'b1;
          else bp_en_d[cmd_idx] = 1'b0;
        end
        default: cmd_err_d = 1'b1;
      endcase
    end

    if (state_d == S_IDLE) halt_pend_d = 1'b0;
    cycle_cnt_d = (state_d == S_HI) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      remain_q     <= 32'd0;
      mode_run_q   <= 1'b0;
      halt_pend_q  <= 1'b0;
      ready_q      <= 1'b0;
      clk_cpu_q    <= 1'b0;
      running_q    <= 1'b0;
      stop_pulse_q <= 1'b0;
      stop_cause_q <= 2'd0;
      bp_idx_q     <= 2'd0;
      cmd_err_q    <= 1'b0;
      cycle_cnt_q  <= 32'd0;
      bp_en_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      remain_q     <= remain_d;
      mode_run_q   <= mode_run_d;
      halt_pend_q  <= halt_pend_d;
      ready_q      <= 1'b1;
      clk_cpu_q    <= (state_d == S_HI);
      running_q    <= (state_d != S_IDLE);
      stop_pulse_q <= stop_pulse_d;
      stop_cause_q <= stop_cause_d;
      bp_idx_q     <= bp_idx_d;
      cmd_err_q    <= cmd_err_d;
      cycle_cnt_q  <= cycle_cnt_d;
      bp_en_q      <= bp_en_d;
    end
  end

  // Addresses are qualified by the enable bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (bp_we) bp_addr_q[cmd_idx] <= cmd_data;
  end

  assign cmd_ready  = ready_q;
  assign clk_cpu    = clk_cpu_q;
  assign running    = running_q;
  assign stop_pulse = stop_pulse_q;
  assign stop_cause = stop_cause_q;
  assign bp_idx     = bp_idx_q;
  assign cmd_err    = cmd_err_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: step, run-to-breakpoint, halt, errors, reset.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        cv, cv2;
  logic [2:0]  cop, cop2;
  logic [1:0]  cidx, cidx2;
  logic [31:0] cdat, cdat2;
  logic [31:0] pc = 32'd0, pc2 = 32'd0;

  logic        rdy, ccpu, run, sp, err;
  logic [1:0]  cause, bpi;
  logic [31:0] ccnt;
  logic        rdy2, ccpu2, run2, sp2, err2;
  logic [1:0]  cause2, bpi2;
  logic [31:0] ccnt2;

  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;
  int pulses_at;
  time t_rise = 0;
  time hi_width = 0;

  cpu_run_ctrl #(.NBP(4)) u_dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cv), .cmd_ready(rdy), .cmd_op(cop),
    .cmd_idx(cidx), .cmd_data(cdat), .pc_chk(pc), .clk_cpu(ccpu),
    .running(run), .stop_pulse(sp), .stop_cause(cause), .bp_idx(bpi),
    .cmd_err(err), .cycle_cnt(ccnt)
  );

  cpu_run_ctrl #(.NBP(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .cmd_valid(cv2), .cmd_ready(rdy2), .cmd_op(cop2),
    .cmd_idx(cidx2), .cmd_data(cdat2), .pc_chk(pc2), .clk_cpu(ccpu2),
    .running(run2), .stop_pulse(sp2), .stop_cause(cause2), .bp_idx(bpi2),
    .cmd_err(err2), .cycle_cnt(ccnt2)
  );

  always #5 clk = ~clk;

  // CPU model: PC advances by 4 on each clk_cpu rising edge.
  always @(posedge ccpu) begin
    pc = pc + 32'd4;
    pulses = pulses + 1;
    t_rise = $time;
  end
  always @(negedge ccpu) hi_width = $time - t_rise;
  always @(posedge ccpu2) pc2 = pc2 + 32'd4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int which, input logic [2:0] op, input logic [1:0] idx,
                      input logic [31:0] data);
    if (which == 1) begin cv = 1'b1; cop = op; cidx = idx; cdat = data; end
    else begin cv2 = 1'b1; cop2 = op; cidx2 = idx; cdat2 = data; end
    @(negedge clk);
    cv = 1'b0; cv2 = 1'b0;
  endtask

  task automatic wait_stop(input int which, input string tag);
    int n = 0;
    while (((which == 1) ? sp : sp2) !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (which == 1) ? sp : sp2, 1'b1);
  endtask

  task automatic wait_hi(input string tag);
    int n = 0;
    @(negedge clk);
    while (ccpu !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk(tag, ccpu, 1'b1);
  endtask

  initial begin
    cv = 0; cop = 0; cidx = 0; cdat = 0;
    cv2 = 0; cop2 = 0; cidx2 = 0; cdat2 = 0;

    @(negedge clk);
    chk("rst_clk_cpu", ccpu, 0);
    chk("rst_running", run, 0);
    chk("rst_cycle_cnt", ccnt, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_cause", cause, 0);
    @(negedge clk);
    rstn = 1'b1;
    chk("ready_still_low", rdy, 0);
    @(negedge clk);
    chk("ready_high", rdy, 1);

    // STEP 3: alternating 1/0 for 6 clk, stop at 6 clk after accept.
    send(1, 3'd0, 2'd0, 32'd3);
    chk("step3_cnt_first", ccnt, 1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("step3_clk_%0d", k), ccpu, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("step3_run_%0d", k), run, 1);
      chk($sformatf("step3_sp_%0d", k), sp, 0);
      @(negedge clk);
    end
    chk("step3_stop_pulse", sp, 1);
    chk("step3_running", run, 0);
    chk("step3_cause", cause, 1);
    chk("step3_cycle_cnt", ccnt, 3);
    chk("step3_pulses", pulses, 3);
    @(negedge clk);
    chk("step3_sp_one_clk", sp, 0);

    // STEP 0 acts as STEP 1.
    send(1, 3'd0, 2'd0, 32'd0);
    chk("step0_clk_hi", ccpu, 1);
    @(negedge clk);
    chk("step0_clk_lo", ccpu, 0);
    @(negedge clk);
    chk("step0_stop_pulse", sp, 1);
    chk("step0_cause", cause, 1);
    chk("step0_cycle_cnt", ccnt, 4);

    // Breakpoint at 0x10 on index 2, run from PC 0.
    @(negedge clk);
    send(1, 3'd3, 2'd2, 32'h10);
    chk("setbp_no_err", err, 0);
    pc = 32'd0;
    pulses = 0;
    send(1, 3'd1, 2'd0, 32'd0);
    wait_stop(1, "bp_stop_seen");
    chk("bp_pulses", pulses, 4);
    chk("bp_pc", pc, 32'h10);
    chk("bp_cause", cause, 2);
    chk("bp_idx", bpi, 2);
    chk("bp_running", run, 0);

    // Rerun from the breakpoint PC: must advance and keep going.
    @(negedge clk);
    send(1, 3'd1, 2'd0, 32'd0);
    chk("rerun_running", run, 1);
    repeat (3) @(negedge clk);
    send(1, 3'd1, 2'd0, 32'd0);
    chk("run_busy_err", err, 1);
    chk("run_busy_running", run, 1);
    @(negedge clk);
    chk("run_busy_err_clear", err, 0);
    send(1, 3'd6, 2'd0, 32'd0);
    chk("op6_err", err, 1);
    repeat (10) @(negedge clk);
    chk("rerun_still_running", run, 1);
    chk("rerun_advanced", (pc > 32'h10) ? 32'd1 : 32'd0, 1);

    // HALT while clk_cpu is high: that pulse finishes, then stop.
    wait_hi("halt_find_hi");
    pulses_at = pulses;
    send(1, 3'd2, 2'd0, 32'd0);
    chk("halt_lo_clk", ccpu, 0);
    chk("halt_lo_running", run, 1);
    @(negedge clk);
    chk("halt_stop_pulse", sp, 1);
    chk("halt_cause", cause, 3);
    chk("halt_width", 32'(hi_width), 10);
    repeat (6) @(negedge clk);
    chk("halt_no_more_edges", pulses, pulses_at);
    chk("halt_clk_low", ccpu, 0);

    // NBP=2 instance: index 3 rejected and not written, index 1 accepted.
    send(2, 3'd3, 2'd3, 32'h8);
    chk("nbp2_idx3_err", err2, 1);
    send(2, 3'd3, 2'd1, 32'h40);
    chk("nbp2_idx1_ok", err2, 0);
    send(2, 3'd1, 2'd0, 32'd0);
    wait_stop(2, "nbp2_stop_seen");
    chk("nbp2_pc", pc2, 32'h40);
    chk("nbp2_cause", cause2, 2);
    chk("nbp2_bp_idx", bpi2, 1);

    // Reset while clk_cpu is high.
    @(negedge clk);
    pc = 32'd0;
    send(1, 3'd1, 2'd0, 32'd0);
    wait_hi("rst_find_hi");
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_clk", ccpu, 0);
    chk("rst_async_running", run, 0);
    pulses_at = pulses;
    @(negedge clk);
    chk("rst2_cycle_cnt", ccnt, 0);
    chk("rst2_cause", cause, 0);
    chk("rst2_bp_idx", bpi, 0);
    chk("rst2_ready", rdy, 0);
    chk("rst2_no_edges", pulses, pulses_at);
    rstn = 1'b1;
    @(negedge clk);
    pc = 32'd0;
    send(1, 3'd1, 2'd0, 32'd0);
    repeat (20) @(negedge clk);
    chk("rst2_bp_disabled", run, 1);
    wait_hi("rst2_find_hi");
    send(1, 3'd2, 2'd0, 32'd0);
    @(negedge clk);
    chk("rst2_halt_cause", cause, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control sequencer for the single-cycle/pipelined test CPU under serial debug. Generates the CPU clock `clk_cpu` from the board clock and executes STEP (N cycles), RUN-until-breakpoint and HALT commands issued by the debug unit's command decoder. Also owns a small breakpoint table matched against `pc_chk`. It sits between the serial debug unit and `CPU_test`, replacing free-running or hand-toggled `clk_cpu` generation.

## Interface
Parameters:
- NBP, 4: number of breakpoint registers (1..4); index width is fixed at 2 bits.

Ports:
- clk  in  1  board clock; all logic is on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command strobe; sampled when `cmd_ready`=1.
- cmd_ready  out  1  constant 1 after reset; every command is accepted in one cycle.
- cmd_op  in  3  0 STEP, 1 RUN, 2 HALT, 3 SETBP, 4 CLRBP; 5-7 are reserved.
- cmd_idx  in  2  breakpoint index for SETBP/CLRBP.
- cmd_data  in  32  STEP: cycle count; SETBP: breakpoint address.
- pc_chk  in  32  current CPU PC; stable during the clk_cpu low phase.
- clk_cpu  out  1  registered CPU clock.
- running  out  1  1 while a STEP or RUN is in progress.
- stop_pulse  out  1  one-clk pulse when a STEP or RUN ends.
- stop_cause  out  2  held from the last stop: 0 none, 1 step done, 2 breakpoint, 3 halt.
- bp_idx  out  2  index of the breakpoint hit at the last stop (valid when stop_cause=2).
- cmd_err  out  1  one-clk pulse for a reserved op, STEP/RUN while running, or an index ≥ NBP.
- cycle_cnt  out  32  total clk_cpu rising edges since reset; wraps.

## Operation
- States are IDLE, HI and LO. clk_cpu is a register equal to 1 exactly while in HI, so it is glitch-free. One CPU cycle takes 2 clk.
- IDLE:
  - STEP loads `remain` = cmd_data, with 0 treated as 1, clears mode_run, and moves to HI.
  - RUN sets mode_run and moves to HI.
  - HALT in IDLE does nothing and does not pulse stop_pulse.
- HI: cycle_cnt increments and the state moves to LO unconditionally.
- LO evaluates the stop conditions in priority order:
  1. A pending halt sets cause 3.
  2. In step mode, when remain-1 == 0, cause 1. Otherwise remain decrements.
  3. In run mode, pc_chk equal to any enabled breakpoint sets cause 2. The lowest matching index goes to bp_idx.
- If any stop condition holds, the block goes to IDLE, pulses stop_pulse and latches stop_cause. Otherwise it returns to HI.
- Breakpoints are checked only after at least one executed cycle, so RUN starting on a breakpoint PC always advances. Step mode ignores breakpoints.
- HALT while running sets `halt_pend`. It takes effect at the next LO, so the in-flight CPU cycle always completes and clk_cpu is never truncated. halt_pend clears on entry to IDLE.
- SETBP writes the address and sets the enable bit; CLRBP clears the enable bit. Both are allowed in any state and are effective from the next LO evaluation.
- If halt and step-done coincide in the same LO, stop_cause reports 3.
- Simultaneous cmd accept and the LO-to-IDLE transition: the command is evaluated against the pre-transition state. A STEP arriving on the stop cycle is rejected with cmd_err.

## Timing
- Reset values: clk_cpu 0, running 0, stop_pulse 0, stop_cause 0, bp_idx 0, cmd_err 0, cycle_cnt 0, all breakpoint enables 0, state IDLE. cmd_ready rises 1 clk after rstn deassertion.
- Reset mid-operation forces clk_cpu low immediately (asynchronously). No further edges are issued.
- Command accepted at edge t gives clk_cpu=1 and running=1 at t+1. clk_cpu falls at t+2.
- STEP N produces exactly N clk_cpu pulses. stop_pulse is high in the clk after the final LO, i.e. 2N clk after acceptance. running falls in that same cycle.
- cycle_cnt updates in the clk where clk_cpu rises.
- cmd_err is asserted for one clk, 1 clk after the offending command.

## Test plan
- STEP with cmd_data=3 from IDLE -> exactly 3 clk_cpu pulses, each 1 clk high and 1 clk low. stop_pulse at 6 clk after accept; stop_cause=1; cycle_cnt=3.
- STEP with cmd_data=0 -> 1 pulse, stop_cause=1.
- SETBP idx 2 = 0x0000_0010, then RUN with a bench PC model (pc += 4 per rising edge, starting at 0) -> stop after 4 pulses with pc_chk=0x10. stop_cause=2, bp_idx=2.
- RUN again from 0x10 with the breakpoint still enabled -> the CPU advances past 0x10. With only that breakpoint enabled, the block keeps running until a HALT is sent. HALT mid-HI -> the current pulse completes with full width, stop_cause=3, and no further clk_cpu edge.
- RUN while running -> cmd_err pulse, and the run is unaffected. Op 6 -> cmd_err. SETBP with idx 3 when NBP=2 -> cmd_err, and the table is unchanged.
- Assert rstn low while clk_cpu=1 -> clk_cpu drops before the next clk edge. All outputs return to their reset values and breakpoints are disabled.
